calculations: RTL and testbench
===============================

Name: calculations

Overview:
- Execute-stage datapath of the 16-bit multi-cycle processor.
- Selects the ALU operands from PC, register A, register B, immediate or constants, and computes the result and flags.
- Registers the result in ALUOut_sr and the register-B value in B_sr.
- Drives the next-PC mux output toward fetch. Sits between the register file/immediate block and fetch/memory; the control FSM drives the select lines.

Parameters:
- WIDTH, 16, datapath width. Must stay 16 in this design.
- PC_INC, 1, constant used for PC increment (memory is word-addressed).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- input_A  in  16  register-file read port A.
- input_B  in  16  register-file read port B.
- input_PC  in  16  current PC.
- input_imm  in  16  sign-extended immediate.
- input_ALUSrcA  in  2  operand-A select.
- input_ALUSrcB  in  2  operand-B select.
- input_ALUOp  in  4  operation select.
- input_PCSrc  in  1  next-PC source select.
- output_ALUOut_sr  out  16  registered ALU result.
- output_ALUMuxOut  out  16  next-PC value (combinational).
- output_Zero  out  1  ALU result == 0 (combinational).
- output_negative  out  1  ALU result bit 15 (combinational).
- output_carry  out  1  carry/no-borrow of ADD/SUB (combinational).
- output_B_sr  out  16  registered input_B (store data).

Behaviour:
- Operand A select (SrcA):
  - 00: input_PC
  - 01: input_A
  - 10: 16'h0000
  - 11: output_ALUOut_sr
- Operand B select (SrcB):
  - 00: input_B
  - 01: PC_INC
  - 10: input_imm
  - 11: 16'h0000
- ALUOp encoding (R = result, opA/opB = selected operands):
  - 0 ADD: opA+opB, carry = bit 16.
  - 1 SUB: opA-opB, carry = 1 when opA >= opB unsigned (no borrow).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~opA.
  - 6 SLL: opA << opB[3:0].
  - 7 SRL: logical right shift by opB[3:0].
  - 8 SRA: arithmetic right shift by opB[3:0].
  - 9 SLT: 16'h0001 if signed opA < opB, else 0.
  - 10 PASSB: R = opB.
  - 11 PASSA: R = opA.
  - 12–15: R = 0 (12 is reassigned under the optional feature).
  - Carry is 0 for every op except ADD and SUB.
- All arithmetic wraps modulo 2^16; no overflow output.
- Zero = (R == 0). Negative = R[15]. Both are combinational from the current R, including for op codes that produce R = 0.
- Next-PC mux: PCSrc=0 → output_ALUMuxOut = R (sequential PC+1 in the same cycle); PCSrc=1 → output_ALUMuxOut = output_ALUOut_sr (branch target computed in an earlier cycle).
- Every rising clk: ALUOut_sr <= R and B_sr <= input_B, unconditionally (no enable).
- When SrcA=11, operand A is the value ALUOut_sr held before the edge; the new value takes effect only after the edge.
- Reset asserted (at any time, including mid-instruction): ALUOut_sr and B_sr go to 0 immediately and stay 0 while reset is high. Combinational outputs keep tracking the inputs during reset.
- First rising edge after reset deasserts captures normally.
- Latency: R, flags and ALUMuxOut are combinational (0 cycles); ALUOut_sr and B_sr are 1 cycle.

Optional Feature:
- CALC_MULT_EN defined: ALUOp 12 = MUL, R = low 16 bits of unsigned opA*opB, carry = 1 if the high 16 bits are nonzero.
- Not defined: ALUOp 12 gives R = 0, carry = 0, and no multiplier is synthesized.

Decomposition:
- Package calc_pkg holds:
  - ALUOp constants/enum (ADD..PASSA, MUL).
  - SrcA enum: PC, A, ZERO, ALUOUT.
  - SrcB enum: B, INC, IMM, ZERO.
  - PCSrc encodings and the WIDTH constant.
- One sub-module, calc_alu: purely combinational (opA, opB, op → R, carry), with zero and negative derived in the parent.
- Operand muxes, PC mux and the two registers live in calculations.

Test Plan:
- Reset, then apply SrcA=00, SrcB=01, ALUOp=ADD, input_PC=16'h0010, PCSrc=0 → ALUMuxOut=16'h0011 immediately; ALUOut_sr=16'h0011 after 1 edge; Zero=0, carry=0.
- SrcA=01, SrcB=00, SUB, A=5, B=5 → R=0, Zero=1, carry=1; with A=3, B=5 → R=16'hFFFE, negative=1, carry=0.
- ADD with A=16'hFFFF, B=16'h0001 → R=0, Zero=1, carry=1; SLT with A=16'hFFFF (−1), B=1 → R=1; SRA with A=16'h8000, imm=4 (SrcB=10) → R=16'hF800.
- Branch: cycle 1 computes PC+imm (16'h0020+16'h0004) into ALUOut_sr; cycle 2 with PCSrc=1 → ALUMuxOut=16'h0024 regardless of the current R.
- input_B=16'hBEEF → output_B_sr=16'hBEEF one edge later; assert reset between edges → ALUOut_sr and B_sr read 0 before the next edge.
- With CALC_MULT_EN: ALUOp=12, A=16'h0100, B=16'h0100 → R=0, carry=1, Zero=1. Without the macro, the same stimulus gives R=0 and carry=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the execute-stage datapath.
// ALU op 12 (OP_MUL) is only implemented when CALC_MULT_EN is defined.
package calc_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SLT   = 4'd9,
    OP_PASSB = 4'd10,
    OP_PASSA = 4'd11,
    OP_MUL   = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCA_PC     = 2'b00,
    SRCA_A      = 2'b01,
    SRCA_ZERO   = 2'b10,
    SRCA_ALUOUT = 2'b11
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_B    = 2'b00,
    SRCB_INC  = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_ZERO = 2'b11
  } src_b_e;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

endpackage

// File: rtl/calc_if.sv
// Operand, control and result bundle between the control/register side and the
// execute stage. Signal names match the execute-stage port list.
interface calc_if;
  import calc_pkg::*;

  logic [WIDTH-1:0] input_A;
  logic [WIDTH-1:0] input_B;
  logic [WIDTH-1:0] input_PC;
  logic [WIDTH-1:0] input_imm;
  logic [1:0]       input_ALUSrcA;
  logic [1:0]       input_ALUSrcB;
  logic [3:0]       input_ALUOp;
  logic             input_PCSrc;
  logic [WIDTH-1:0] output_ALUOut_sr;
  logic [WIDTH-1:0] output_ALUMuxOut;
  logic             output_Zero;
  logic             output_negative;
  logic             output_carry;
  logic [WIDTH-1:0] output_B_sr;

  modport master (
    output input_A, input_B, input_PC, input_imm,
    output input_ALUSrcA, input_ALUSrcB, input_ALUOp, input_PCSrc,
    input  output_ALUOut_sr, output_ALUMuxOut, output_Zero,
    input  output_negative, output_carry, output_B_sr
  );

  modport slave (
    input  input_A, input_B, input_PC, input_imm,
    input  input_ALUSrcA, input_ALUSrcB, input_ALUOp, input_PCSrc,
    output output_ALUOut_sr, output_ALUMuxOut, output_Zero,
    output output_negative, output_carry, output_B_sr
  );

endinterface

// File: rtl/calc_alu.sv
// Purely combinational ALU: result and carry from two operands and an op code.
// CALC_MULT_EN adds an unsigned multiplier on op 12; otherwise op 12 yields zero.
module calc_alu
  import calc_pkg::*;
(
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [3:0]     shamt;

  assign sum   = {1'b0, opa} + {1'b0, opb};
  assign diff  = {1'b0, opa} - {1'b0, opb};
  assign shamt = opb[3:0];

`ifdef CALC_MULT_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
`endif

  always_comb begin
    r     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        r     = diff[WIDTH-1:0];
        // diff[WIDTH] is the borrow; carry reports "no borrow"
        carry = ~diff[WIDTH];
      end
      OP_AND:   r = opa & opb;
      OP_OR:    r = opa | opb;
      OP_XOR:   r = opa ^ opb;
      OP_NOT:   r = ~opa;
      OP_SLL:   r = opa << shamt;
      OP_SRL:   r = opa >> shamt;
      OP_SRA:   r = $unsigned($signed(opa) >>> shamt);
      OP_SLT:   r = ($signed(opa) < $signed(opb)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      OP_PASSB: r = opb;
      OP_PASSA: r = opa;
`ifdef CALC_MULT_EN
      OP_MUL: begin
        r     = prod[WIDTH-1:0];
        carry = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: begin
        r     = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calculations.sv
// Execute stage: operand muxes, ALU, next-PC mux and the ALUOut/B registers.
// Op 12 becomes MUL when CALC_MULT_EN is defined (see calc_alu).
module calculations
  import calc_pkg::*;
#(
  parameter logic [WIDTH-1:0] PC_INC = 16'd1
) (
  input  logic clk,
  input  logic reset,
  calc_if.slave bus
);

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] r;
  logic             carry;
  logic [WIDTH-1:0] aluout_d, aluout_q;
  logic [WIDTH-1:0] b_d, b_q;

  always_comb begin
    opa = '0;
    case (bus.input_ALUSrcA)
      SRCA_PC:     opa = bus.input_PC;
      SRCA_A:      opa = bus.input_A;
      SRCA_ZERO:   opa = '0;
      SRCA_ALUOUT: opa = aluout_q;
      default:     opa = '0;
    endcase
  end

  always_comb begin
    opb = '0;
    case (bus.input_ALUSrcB)
      SRCB_B:    opb = bus.input_B;
      SRCB_INC:  opb = PC_INC;
      SRCB_IMM:  opb = bus.input_imm;
      SRCB_ZERO: opb = '0;
      default:   opb = '0;
    endcase
  end

  calc_alu u_alu (
    .opa   (opa),
    .opb   (opb),
    .op    (bus.input_ALUOp),
    .r     (r),
    .carry (carry)
  );

  always_comb begin
    aluout_d = r;
    b_d      = bus.input_B;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluout_q <= '0;
      b_q      <= '0;
    end else begin
      aluout_q <= aluout_d;
      b_q      <= b_d;
    end
  end

  // PCSrc=1 selects a branch target computed in an earlier cycle
  assign bus.output_ALUMuxOut = (bus.input_PCSrc == PCSRC_ALUOUT) ? aluout_q : r;
  assign bus.output_ALUOut_sr = aluout_q;
  assign bus.output_B_sr      = b_q;
  assign bus.output_Zero      = (r == '0);
  assign bus.output_negative  = r[WIDTH-1];
  assign bus.output_carry     = carry;

endmodule

// File: tb/tb_calculations.sv
// Self-checking bench for the execute stage; expectations follow CALC_MULT_EN if defined.
module tb_calculations;
  import calc_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  calc_if bus ();

  calculations dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  srca;
    logic [1:0]  srcb;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        c;
  } vec_t;

  typedef struct {
    logic [15:0] r;
    logic [15:0] b;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[21];

  function automatic vec_t mk(input logic [1:0] srca, input logic [1:0] srcb,
                              input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] pc,
                              input logic [15:0] imm, input logic [15:0] r,
                              input logic c);
    vec_t v;
    v.srca = srca; v.srcb = srcb; v.op = op;
    v.a = a; v.b = b; v.pc = pc; v.imm = imm;
    v.r = r; v.z = (r == 16'h0000); v.n = r[15]; v.c = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic pcsrc);
    bus.input_ALUSrcA = v.srca;
    bus.input_ALUSrcB = v.srcb;
    bus.input_ALUOp   = v.op;
    bus.input_A       = v.a;
    bus.input_B       = v.b;
    bus.input_PC      = v.pc;
    bus.input_imm     = v.imm;
    bus.input_PCSrc   = pcsrc;
  endtask

  initial begin
    sb_t  e;
    vec_t v;
    logic mul_c;

`ifdef CALC_MULT_EN
    mul_c = 1'b1;
`else
    mul_c = 1'b0;
`endif

    vecs[0]  = mk(2'b00, 2'b01, 4'd0,  16'h0000, 16'h0101, 16'h0010, 16'h0000, 16'h0011, 1'b0);
    vecs[1]  = mk(2'b01, 2'b00, 4'd1,  16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    vecs[2]  = mk(2'b01, 2'b00, 4'd1,  16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'hFFFE, 1'b0);
    vecs[3]  = mk(2'b01, 2'b00, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    vecs[4]  = mk(2'b01, 2'b00, 4'd9,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b0);
    vecs[5]  = mk(2'b01, 2'b10, 4'd8,  16'h8000, 16'h0007, 16'h0000, 16'h0004, 16'hF800, 1'b0);
    vecs[6]  = mk(2'b01, 2'b00, 4'd2,  16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 16'h3030, 1'b0);
    vecs[7]  = mk(2'b01, 2'b00, 4'd3,  16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 16'hFCFC, 1'b0);
    vecs[8]  = mk(2'b01, 2'b00, 4'd4,  16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 16'hCCCC, 1'b0);
    vecs[9]  = mk(2'b01, 2'b00, 4'd5,  16'h00FF, 16'h1234, 16'h0000, 16'h0000, 16'hFF00, 1'b0);
    vecs[10] = mk(2'b01, 2'b00, 4'd6,  16'h0001, 16'h000F, 16'h0000, 16'h0000, 16'h8000, 1'b0);
    vecs[11] = mk(2'b01, 2'b00, 4'd7,  16'h8000, 16'h0013, 16'h0000, 16'h0000, 16'h1000, 1'b0);
    vecs[12] = mk(2'b01, 2'b10, 4'd10, 16'h5555, 16'hAAAA, 16'h0000, 16'h1234, 16'h1234, 1'b0);
    vecs[13] = mk(2'b10, 2'b00, 4'd11, 16'h5555, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    vecs[14] = mk(2'b01, 2'b00, 4'd13, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    vecs[15] = mk(2'b01, 2'b00, 4'd12, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, mul_c);
`ifdef CALC_MULT_EN
    vecs[16] = mk(2'b01, 2'b00, 4'd12, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'h000F, 1'b0);
`else
    vecs[16] = mk(2'b01, 2'b00, 4'd12, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b0);
`endif
    vecs[17] = mk(2'b01, 2'b00, 4'd9,  16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    vecs[18] = mk(2'b10, 2'b11, 4'd1,  16'h7777, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    vecs[19] = mk(2'b01, 2'b11, 4'd0,  16'h0007, 16'h4321, 16'h0000, 16'h0000, 16'h0007, 1'b0);
    vecs[20] = mk(2'b00, 2'b10, 4'd0,  16'h0000, 16'h0000, 16'hFFF0, 16'h0020, 16'h0010, 1'b1);

    // Reset: registers held at zero, combinational path still live
    reset = 1'b1;
    v = mk(2'b01, 2'b11, 4'd11, 16'h1234, 16'h9999, 16'h0000, 16'h0000, 16'h1234, 1'b0);
    drive(v, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_aluout", {16'h0, bus.output_ALUOut_sr}, 32'h0);
    chk("reset_bsr", {16'h0, bus.output_B_sr}, 32'h0);
    chk("reset_mux_live", {16'h0, bus.output_ALUMuxOut}, 32'h1234);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i], 1'b0);
      #2;
      chk($sformatf("v%0d_mux", i), {16'h0, bus.output_ALUMuxOut}, {16'h0, vecs[i].r});
      chk($sformatf("v%0d_zero", i), {31'h0, bus.output_Zero}, {31'h0, vecs[i].z});
      chk($sformatf("v%0d_neg", i), {31'h0, bus.output_negative}, {31'h0, vecs[i].n});
      chk($sformatf("v%0d_carry", i), {31'h0, bus.output_carry}, {31'h0, vecs[i].c});
      e.r = vecs[i].r;
      e.b = vecs[i].b;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_aluout_sr", i), {16'h0, bus.output_ALUOut_sr}, {16'h0, e.r});
        chk($sformatf("v%0d_b_sr", i), {16'h0, bus.output_B_sr}, {16'h0, e.b});
      end
    end

    // Branch: target into ALUOut_sr, then PCSrc=1 selects it over current R
    @(negedge clk);
    v = mk(2'b00, 2'b10, 4'd0, 16'h0000, 16'h0000, 16'h0020, 16'h0004, 16'h0024, 1'b0);
    drive(v, 1'b0);
    @(posedge clk);
    #1;
    chk("br_target_sr", {16'h0, bus.output_ALUOut_sr}, 32'h0024);
    @(negedge clk);
    v = mk(2'b00, 2'b01, 4'd0, 16'h0000, 16'h0000, 16'h0021, 16'h0000, 16'h0022, 1'b0);
    drive(v, 1'b1);
    #2;
    chk("br_mux_pcsrc1", {16'h0, bus.output_ALUMuxOut}, 32'h0024);
    chk("br_zero_from_r", {31'h0, bus.output_Zero}, 32'h0);

    // SrcA=ALUOUT uses the pre-edge register value, then the new one
    @(negedge clk);
    v = mk(2'b11, 2'b01, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    drive(v, 1'b0);
    #2;
    chk("fb_r_before", {16'h0, bus.output_ALUMuxOut}, 32'h0023);
    @(posedge clk);
    #1;
    chk("fb_sr_after", {16'h0, bus.output_ALUOut_sr}, 32'h0023);
    chk("fb_r_after", {16'h0, bus.output_ALUMuxOut}, 32'h0024);

    // Store data capture, then reset pulse between edges
    @(negedge clk);
    v = mk(2'b00, 2'b01, 4'd0, 16'h0000, 16'hBEEF, 16'h0010, 16'h0000, 16'h0011, 1'b0);
    drive(v, 1'b0);
    @(posedge clk);
    #1;
    chk("bsr_beef", {16'h0, bus.output_B_sr}, 32'hBEEF);
    chk("aluout_0011", {16'h0, bus.output_ALUOut_sr}, 32'h0011);
    #1 reset = 1'b1;
    #1;
    chk("midreset_aluout", {16'h0, bus.output_ALUOut_sr}, 32'h0);
    chk("midreset_bsr", {16'h0, bus.output_B_sr}, 32'h0);
    chk("midreset_mux_live", {16'h0, bus.output_ALUMuxOut}, 32'h0011);
    #1 reset = 1'b0;
    @(negedge clk);
    bus.input_B = 16'h1111;
    @(posedge clk);
    #1;
    chk("post_reset_bsr", {16'h0, bus.output_B_sr}, 32'h1111);
    chk("post_reset_aluout", {16'h0, bus.output_ALUOut_sr}, 32'h0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
